pic_uart_tx: RTL and testbench

PIC_UART_TX -- requirements
Module: pic_uart_tx

---
 rtl/pic_uart_tx_if.sv | 31 +++
 rtl/pic_uart_tx.sv | 114 +++++++++++
 tb/tb_pic_uart_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pic_uart_tx_if.sv
// Bus bundle between the picture UART transmitter and its host/memory side.
// The master drives the frame request and memory read data; the slave is the transmitter.
interface pic_uart_tx_if;
  logic        start;
  logic [7:0]  rd_data;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output rd_data,
    input  rd_en,
    input  rd_addr,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  rd_data,
    output rd_en,
    output rd_addr,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/pic_uart_tx.sv
// Streams a PIC_SIZE-byte picture from a synchronous-read memory out of an 8N1 UART line.
// Each byte costs one FETCH cycle, one LATCH cycle and ten bit periods of BAUD_CNT_MAX cycles.
module pic_uart_tx #(
  parameter int unsigned BAUD_CNT_MAX = 5208,
  parameter int unsigned PIC_SIZE     = 10_000
) (
  input logic         sys_clk,
  input logic         sys_rst,
  pic_uart_tx_if.slave bus
);

  localparam int unsigned BaudW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_CNT_MAX - 1);
  localparam logic [13:0]      IdxLast  = 14'(PIC_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLatch, StSend} state_e;

  state_e            state_q, state_d;
  logic [13:0]       idx_q, idx_d;
  logic [13:0]       addr_q, addr_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  // State register with synchronous reset that aborts any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; tx_d is set one cycle ahead so the line is a clean flop output.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (bus.start) begin
          state_d = StFetch;
          idx_d   = '0;
          addr_d  = '0;
        end
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        // Memory data is valid now; preload the start bit for the first SEND cycle.
        shreg_d = bus.rd_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            tx_d = 1'b1;
            if (idx_q == IdxLast) begin
              idx_d   = '0;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + 14'd1;
              addr_d  = idx_q + 14'd1;
              state_d = StFetch;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            // After data bit 7 (frame bit 8) comes the stop bit.
            tx_d    = (bit_q == 4'd8) ? 1'b1 : shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rd_en   = (state_q == StFetch);
  assign bus.rd_addr = addr_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_pic_uart_tx.sv
// Directed bench for pic_uart_tx with BAUD_CNT_MAX=4, PIC_SIZE=3 (42-cycle bytes, 126-cycle frames).
module tb_pic_uart_tx;

  localparam int Per   = 42;
  localparam int Frame = 126;

  logic clk;
  logic rst;
  pic_uart_tx_if bus ();

  pic_uart_tx #(
    .BAUD_CNT_MAX(4),
    .PIC_SIZE(3)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  logic [7:0] mem [0:3];

  // Synchronous-read picture memory: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= (bus.rd_addr < 14'd3) ? mem[bus.rd_addr[1:0]] : 8'h00;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic        cap_en   [0:299];
  logic [13:0] cap_addr [0:299];
  logic        cap_tx   [0:299];
  logic        cap_busy [0:299];
  logic        cap_done [0:299];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // mode 0: start low, 1: start pulsed every 10 cycles early in the frame, 2: start held high
  task automatic capture(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_en[c]   = bus.rd_en;
      cap_addr[c] = bus.rd_addr;
      cap_tx[c]   = bus.tx;
      cap_busy[c] = bus.busy;
      cap_done[c] = bus.done;
      case (mode)
        0:       bus.start = 1'b0;
        1:       bus.start = (c < 120) && (c % 10 == 9);
        default: bus.start = 1'b1;
      endcase
    end
  endtask

  // Expected line value c cycles after the first FETCH of a single frame.
  function automatic logic exp_tx(input int c);
    int b;
    int off;
    logic [9:0] fr;
    b   = c / Per;
    off = c % Per;
    if (b >= 3 || off < 2) return 1'b1;
    fr = {1'b1, mem[b], 1'b0};
    return fr[(off - 2) / 4];
  endfunction

  initial begin
    int bad;
    int cnt;
    int maxa;
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hFF;
    mem[3] = 8'h00;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;

    // Idle for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("idle_100", bad, 0);

    // Single frame
    bus.start = 1'b1;
    capture(140, 0);
    for (int b = 0; b < 3; b++) begin
      check($sformatf("fetch_en_b%0d", b), cap_en[b*Per], 1);
      check($sformatf("fetch_addr_b%0d", b), cap_addr[b*Per], b);
      bad = 0;
      for (int k = 0; k < Per; k++) if (cap_tx[b*Per+k] !== exp_tx(b*Per+k)) bad++;
      check($sformatf("tx_bits_b%0d", b), bad, 0);
    end
    cnt = 0;
    for (int c = 0; c < 140; c++) if (cap_en[c]) cnt++;
    check("rd_en_count", cnt, 3);
    check("done_at_126", cap_done[Frame], 1);
    cnt = 0;
    for (int c = 0; c < 140; c++) if (cap_done[c]) cnt++;
    check("done_count", cnt, 1);
    check("busy_last_send", cap_busy[Frame-1], 1);
    check("busy_done_cycle", cap_busy[Frame], 0);
    bad = 0;
    for (int c = Frame; c < 140; c++) if (cap_tx[c] !== 1'b1) bad++;
    check("tx_idle_after", bad, 0);

    // start re-pulsed while busy
    bus.start = 1'b1;
    capture(200, 1);
    cnt = 0;
    maxa = 0;
    for (int c = 0; c < 200; c++) begin
      if (cap_en[c]) cnt++;
      if (int'(cap_addr[c]) > maxa) maxa = int'(cap_addr[c]);
    end
    check("repulse_rd_en_count", cnt, 3);
    check("repulse_max_addr", maxa, 2);
    cnt = 0;
    for (int c = 0; c < 200; c++) if (cap_done[c]) cnt++;
    check("repulse_done_count", cnt, 1);
    check("repulse_done_at_126", cap_done[Frame], 1);

    // start held high: back-to-back frames
    bus.start = 1'b1;
    capture(260, 2);
    check("b2b_done1", cap_done[Frame], 1);
    check("b2b_refetch_en", cap_en[Frame+1], 1);
    check("b2b_refetch_addr", cap_addr[Frame+1], 0);
    check("b2b_done2", cap_done[2*Frame+1], 1);
    cnt = 0;
    for (int c = 0; c < 260; c++) if (cap_en[c]) cnt++;
    check("b2b_rd_en_count", cnt, 7);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_drain", bus.busy, 0);
    repeat (2) @(negedge clk);

    // Reset during bit 3 of byte 1
    bus.start = 1'b1;
    capture(58, 0);
    check("pre_rst_tx_bit3", cap_tx[57], 1);
    check("pre_rst_busy", cap_busy[57], 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", bus.tx, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;
    capture(150, 0);
    cnt = 0;
    for (int c = 0; c < 150; c++) if (cap_done[c] || cap_busy[c]) cnt++;
    check("abort_quiet", cnt, 0);
    bus.start = 1'b1;
    capture(50, 0);
    check("restart_en", cap_en[0], 1);
    check("restart_addr", cap_addr[0], 0);
    check("restart_start_bit", cap_tx[2], 0);
    check("restart_bit0", cap_tx[6], 1);
    check("restart_b1_addr", cap_addr[Per], 1);

    // Reset wins over start in the same cycle
    cnt = 0;
    while (bus.busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", bus.busy, 0);
    check("rst_prio_rd_en", bus.rd_en, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_prio_after", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
